// File: rtl/module_bin2bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD converter.
// Optional leading-zero blanking is controlled by BIN2BCD_BLANK_EN.
package calc_pkg;

    localparam int SUM_W      = 13;
    localparam int BCD_DIGITS = 4;
    localparam int CNT_W      = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Enable mask that turns off every digit above the most significant nonzero one.
    function automatic logic [BCD_DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] bcd_val);
        logic [BCD_DIGITS-1:0] mask;
        logic                  seen;
        mask = '0;
        seen = 1'b0;
        for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
            seen    = seen | (bcd_val[4*i +: 4] != 4'd0);
            mask[i] = seen;
        end
        mask[0] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/module_bin2bcd_if.sv
// Request/result bundle between the adder front end and the BCD converter.
interface module_bin2bcd_if;
    import calc_pkg::*;

    logic [SUM_W-1:0]      bin;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [BCD_W-1:0]      bcd;
    logic [BCD_DIGITS-1:0] digit_en;

    modport master (
        output bin,
        output start,
        input  busy,
        input  done,
        input  bcd,
        input  digit_en
    );

    modport slave (
        input  bin,
        input  start,
        output busy,
        output done,
        output bcd,
        output digit_en
    );

endinterface

// File: rtl/module_bin2bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module module_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/module_bin2bcd.sv
// Sequential double-dabble converter: one bit per cycle, result registered at the last shift.
// Define BIN2BCD_BLANK_EN to enable leading-zero blanking on digit_en.
module module_bin2bcd
    import calc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    module_bin2bcd_if.slave bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0] scr_q, scr_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             done_q, done_d;
    logic [BCD_W-1:0] corr;
    logic [BCD_W-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
            module_add3 u_add3 (
                .d_i (scr_q[4*gi +: 4]),
                .d_o (corr[4*gi +: 4])
            );
        end
    endgenerate

    // Corrected scratch shifted left by one, taking in the next binary MSB.
    assign shifted = {corr[BCD_W-2:0], sh_q[SUM_W-1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_d    = bus.bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = shifted;
                sh_d  = {sh_q[SUM_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SUM_W - 1)) begin
                    state_d = DONE;
                    bcd_d   = shifted;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [BCD_DIGITS-1:0] den_q, den_d;

    always_comb begin
        den_d = den_q;
        if (state_q == SHIFT && cnt_q == CNT_W'(SUM_W - 1)) begin
            den_d = blank_mask(shifted);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            den_q <= BCD_DIGITS'(1);
        end else begin
            den_q <= den_d;
        end
    end

    assign bus.digit_en = den_q;
`else
    assign bus.digit_en = '1;
`endif

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_module_bin2bcd.sv
// Randomized bench for module_bin2bcd: an arithmetic reference model checked every cycle,
// plus directed cases with hand-computed expected digits.
module tb_module_bin2bcd;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    module_bin2bcd_if bus ();

    module_bin2bcd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef BIN2BCD_BLANK_EN
    localparam logic [3:0] DEN_RST = 4'b0001;
`else
    localparam logic [3:0] DEN_RST = 4'b1111;
`endif

    int checks = 0;
    int fails  = 0;
    int ncyc   = 0;
    int ndone  = 0;

    function automatic logic [15:0] ref_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] ref_den(input int v);
`ifdef BIN2BCD_BLANK_EN
        if (v >= 1000) return 4'b1111;
        if (v >= 100)  return 4'b0111;
        if (v >= 10)   return 4'b0011;
        return 4'b0001;
`else
        if (v < 0) return 4'b0000;
        return 4'b1111;
`endif
    endfunction

    // Reference model: m_t counts edges since the accepting edge, -1 when idle.
    int          m_t    = -1;
    int          m_held = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_bcd  = '0;
    logic [3:0]  m_den  = DEN_RST;

    always @(posedge clk) begin
        if (rst) begin
            m_t    <= -1;
            m_done <= 1'b0;
            m_bcd  <= '0;
            m_den  <= DEN_RST;
        end else if (m_t < 0) begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_t    <= 0;
                m_held <= int'(bus.bin);
            end
        end else if (m_t == 12) begin
            m_t    <= 13;
            m_done <= 1'b1;
            m_bcd  <= ref_bcd(m_held);
            m_den  <= ref_den(m_held);
        end else if (m_t == 13) begin
            m_t    <= -1;
            m_done <= 1'b0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Advance one clock and compare every output against the model.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        ncyc++;
        if (bus.done === 1'b1) ndone++;
        chk("busy", 32'(bus.busy), 32'(m_t >= 0));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("bcd", 32'(bus.bcd), 32'(m_bcd));
        chk("digit_en", 32'(bus.digit_en), 32'(m_den));
    endtask

    task automatic convert(input int v, output int lat, output int nbusy);
        int d0;
        d0        = ndone;
        bus.start = 1'b1;
        bus.bin   = 13'(v);
        cycle();
        bus.start = 1'b0;
        lat       = 0;
        nbusy     = (bus.busy === 1'b1) ? 1 : 0;
        while (ndone == d0 && lat < 30) begin
            bus.bin = 13'($urandom_range(0, 8191));
            cycle();
            lat++;
            if (bus.busy === 1'b1) nbusy++;
        end
        chk("done_seen", 32'(ndone - d0), 32'd1);
        $display("conv bin=%0d bcd=%04h digit_en=%04b latency=%0d", v, bus.bcd, bus.digit_en, lat);
    endtask

    initial begin
        int lat, nbusy, d0, prev;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) cycle();
        rst = 1'b0;
        chk("rst_bcd", 32'(bus.bcd), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_digit_en", 32'(bus.digit_en), 32'(DEN_RST));

        // Zero input: latency and busy width
        convert(0, lat, nbusy);
        chk("zero_latency", 32'(lat), 32'd13);
        chk("zero_bcd", 32'(bus.bcd), 32'h0000);
        chk("zero_busy_cycles", 32'(nbusy), 32'd14);
        cycle();
        chk("idle_after_done", 32'(bus.busy), 32'h0);

        convert(8190, lat, nbusy);
        chk("max_bcd", 32'(bus.bcd), 32'h8190);
        cycle();
        convert(560, lat, nbusy);
        chk("typ_bcd", 32'(bus.bcd), 32'h0560);
        chk("model_560", 32'(m_bcd), 32'h0560);
        cycle();
        convert(3, lat, nbusy);
        chk("three_bcd", 32'(bus.bcd), 32'h0003);
        cycle();
        convert(8191, lat, nbusy);
        chk("over_bcd", 32'(bus.bcd), 32'h8191);
        cycle();

        // Second start while busy is dropped
        d0 = ndone;
        bus.start = 1'b1; bus.bin = 13'd200;
        cycle();
        bus.start = 1'b0;
        repeat (4) cycle();
        bus.start = 1'b1; bus.bin = 13'd99;
        cycle();
        bus.start = 1'b0;
        repeat (20) cycle();
        chk("busy_start_dones", 32'(ndone - d0), 32'd1);
        chk("busy_start_bcd", 32'(bus.bcd), 32'h0200);
        $display("start-while-busy: dones=%0d bcd=%04h", ndone - d0, bus.bcd);

        // Reset in the middle of a conversion
        bus.start = 1'b1; bus.bin = 13'd4321;
        cycle();
        bus.start = 1'b0;
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_bcd", 32'(bus.bcd), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_digit_en", 32'(bus.digit_en), 32'(DEN_RST));
        d0 = ndone;
        repeat (20) cycle();
        chk("midrst_no_done", 32'(ndone - d0), 32'd0);
        $display("reset mid-conversion: dones=%0d", ndone - d0);
        convert(77, lat, nbusy);
        chk("after_rst_bcd", 32'(bus.bcd), 32'h0077);
        cycle();

        // Blanking cases
`ifdef BIN2BCD_BLANK_EN
        convert(5, lat, nbusy);    chk("blank_5", 32'(bus.digit_en), 32'b0001);    cycle();
        convert(1005, lat, nbusy); chk("blank_1005", 32'(bus.digit_en), 32'b1111); cycle();
        convert(40, lat, nbusy);   chk("blank_40", 32'(bus.digit_en), 32'b0011);   cycle();
`else
        convert(5, lat, nbusy);    chk("blank_5", 32'(bus.digit_en), 32'b1111);    cycle();
        convert(1005, lat, nbusy); chk("blank_1005", 32'(bus.digit_en), 32'b1111); cycle();
        convert(40, lat, nbusy);   chk("blank_40", 32'(bus.digit_en), 32'b1111);   cycle();
`endif

        // start held high: one conversion every 15 cycles
        prev = -1;
        bus.start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            d0 = ndone;
            bus.bin = 13'($urandom_range(0, 8191));
            cycle();
            if (ndone != d0) begin
                if (prev >= 0) chk("b2b_gap", 32'(ncyc - prev), 32'd15);
                $display("b2b done at cycle %0d bcd=%04h", ncyc, bus.bcd);
                prev = ncyc;
            end
        end
        bus.start = 1'b0;
        repeat (16) cycle();

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.bin   = 13'($urandom_range(0, 8191));
            rst       = ($urandom_range(0, 299) == 0);
            d0 = ndone;
            cycle();
            if (ndone != d0) $display("rand done cycle %0d bcd=%04h digit_en=%04b", ncyc, bus.bcd, bus.digit_en);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
